// File: rtl/dest_reg_tracker_pkg.sv
// Shared pipeline definitions for the destination-register tracker.
// Provides the register address width, the hard-wired zero register
// number, the ALU forward-select encodings and the history entry type.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // One slot of the EX/MEM or MEM/WB destination history.
    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } dst_entry_t;

endpackage

// File: rtl/dest_reg_tracker_if.sv
// Bus between the EX/ID pipeline control and the destination-register tracker.
// master: the pipeline side, which drives the EX/ID register numbers and
//         qualifiers and consumes the forward selects, stall and history.
// slave:  the tracker itself.
// Signals:
//   ex_dst, ex_valid, ex_reg_write, ex_mem_read  EX instruction destination/qualifiers
//   ex_rs, ex_rt                                 EX source registers
//   id_rs, id_rt, id_uses_rt                     ID source registers
//   flush                                        squash the EX instruction
//   forward_a, forward_b                         ALU operand selects
//   stall                                        load-use hold
//   mem_dst, wb_dst, wb_reg_write                registered history
//   stall_count                                  saturating stall-event count
interface dest_reg_tracker_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);

    logic [REG_AW-1:0] ex_dst;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              flush;

    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              stall;
    logic [REG_AW-1:0] mem_dst;
    logic [REG_AW-1:0] wb_dst;
    logic              wb_reg_write;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output ex_dst, ex_valid, ex_reg_write, ex_mem_read,
        output ex_rs, ex_rt, id_rs, id_rt, id_uses_rt, flush,
        input  forward_a, forward_b, stall,
        input  mem_dst, wb_dst, wb_reg_write, stall_count
    );

    modport slave (
        input  ex_dst, ex_valid, ex_reg_write, ex_mem_read,
        input  ex_rs, ex_rt, id_rs, id_rt, id_uses_rt, flush,
        output forward_a, forward_b, stall,
        output mem_dst, wb_dst, wb_reg_write, stall_count
    );

endinterface

// File: rtl/dest_reg_tracker_fwd_select.sv
// Forward-select for one ALU operand.
// Ports:
//   src       source register read by the EX instruction
//   mem_entry EX/MEM history entry
//   wb_entry  MEM/WB history entry
//   sel       2-bit operand select (regfile / EX/MEM / MEM/WB)
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  dst_entry_t        mem_entry,
    input  dst_entry_t        wb_entry,
    output logic [1:0]        sel
);

    // The younger producer (MEM) wins when both stages write the same register.
    always_comb begin
        sel = FWD_RF;
        if (mem_entry.reg_write && (mem_entry.dst != REG_ZERO) && (mem_entry.dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_entry.reg_write && (wb_entry.dst != REG_ZERO) && (wb_entry.dst == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/dest_reg_tracker.sv
// Destination-register tracker.
// Carries the EX destination register and its write qualifier through a
// two-entry history (EX/MEM, MEM/WB), derives the ALU forward selects from
// it, raises the one-cycle load-use stall and counts stall events with a
// saturating counter.
// Ports:
//   clk  pipeline clock, rising edge
//   rst  synchronous active-high reset
//   bus  tracker side of dest_reg_tracker_if (EX/ID inputs, selects, stall,
//        history and stall_count outputs)
module dest_reg_tracker
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = pipe_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    dest_reg_tracker_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    dst_entry_t        mem_q;
    dst_entry_t        wb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stall_c;
    logic [REG_AW-1:0] ex_dst;

    assign ex_dst = bus.ex_dst;

    // A load in EX whose target is read by the instruction in ID must hold
    // one cycle; a flushed load never causes a stall.
    always_comb begin
        stall_c = bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write && !bus.flush
                  && (ex_dst != REG_ZERO)
                  && ((ex_dst == bus.id_rs) || (bus.id_uses_rt && (ex_dst == bus.id_rt)));
    end

    // The history advances every cycle, stall included; the bubble arrives
    // through ex_valid=0 on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q.dst       <= ex_dst;
            mem_q.reg_write <= bus.ex_reg_write && bus.ex_valid && !bus.flush;
            wb_q            <= mem_q;
            if (stall_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    fwd_select u_fwd_a (
        .src       (bus.ex_rs),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (bus.forward_a)
    );

    fwd_select u_fwd_b (
        .src       (bus.ex_rt),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (bus.forward_b)
    );

    assign bus.stall        = stall_c;
    assign bus.mem_dst      = mem_q.dst;
    assign bus.wb_dst       = wb_q.dst;
    assign bus.wb_reg_write = wb_q.reg_write;
    assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Self-checking bench for dest_reg_tracker: directed scenarios followed by
// randomized traffic, all compared against a queue-based history model.
module tb_dest_reg_tracker;

    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 4;
    localparam int unsigned MAXCT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dest_reg_tracker_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    dest_reg_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned dst;
        bit          we;
    } ent_t;

    // Index 0 = most recently issued EX instruction (now in MEM), 1 = older.
    ent_t        hist[$];
    int unsigned model_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ent_t z;
        z.dst = 0;
        z.we  = 1'b0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        model_cnt = 0;
    endfunction

    // Youngest non-zero writer of src decides the select.
    function automatic logic [1:0] model_fwd(input int unsigned src);
        for (int i = 0; i < 2; i++) begin
            if (hist[i].we && hist[i].dst != 0 && hist[i].dst == src)
                return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        int unsigned d;
        d = bus.ex_dst;
        return bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write && !bus.flush && d != 0 &&
               (d == bus.id_rs || (bus.id_uses_rt && d == bus.id_rt));
    endfunction

    // Compare every output with the model, then clock and advance the model.
    task automatic tick();
        ent_t e;
        bit   s;
        #1;
        s = model_stall();
        check("fwd_a",  {30'd0, bus.forward_a}, {30'd0, model_fwd(bus.ex_rs)});
        check("fwd_b",  {30'd0, bus.forward_b}, {30'd0, model_fwd(bus.ex_rt)});
        check("stall",  {31'd0, bus.stall}, {31'd0, s});
        check("mem_dst", {27'd0, bus.mem_dst}, hist[0].dst);
        check("wb_dst",  {27'd0, bus.wb_dst}, hist[1].dst);
        check("wb_we",   {31'd0, bus.wb_reg_write}, {31'd0, hist[1].we});
        check("count",   {28'd0, bus.stall_count}, model_cnt);
        if (rst) begin
            model_reset();
        end else begin
            e.dst = bus.ex_dst;
            e.we  = bus.ex_reg_write && bus.ex_valid && !bus.flush;
            hist.push_front(e);
            void'(hist.pop_back());
            if (s && model_cnt < MAXCT) model_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_dst       = '0;
        bus.ex_valid     = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_rs        = '0;
        bus.ex_rt        = '0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic set_ex(input int unsigned dst, input bit we, input bit mr);
        bus.ex_valid     = 1'b1;
        bus.ex_dst       = dst[AW-1:0];
        bus.ex_reg_write = we;
        bus.ex_mem_read  = mr;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset with a writing instruction presented in EX.
        set_ex(5, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        bus.ex_rs = 5'd5;
        bus.ex_rt = 5'd5;
        #1;
        check("rst_fwd_a", {30'd0, bus.forward_a}, 32'd0);
        check("rst_fwd_b", {30'd0, bus.forward_b}, 32'd0);
        check("rst_mem_dst", {27'd0, bus.mem_dst}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_count", {28'd0, bus.stall_count}, 32'd0);
        tick();

        // MEM then WB forwarding of $8.
        idle(); set_ex(8, 1'b1, 1'b0); tick();
        idle(); bus.ex_rs = 5'd8; #1;
        check("memfwd_a", {30'd0, bus.forward_a}, 32'b10);
        tick();
        idle(); bus.ex_rt = 5'd8; #1;
        check("wbfwd_b", {30'd0, bus.forward_b}, 32'b01);
        tick();
        idle(); bus.ex_rs = 5'd8; bus.ex_rt = 5'd8; #1;
        check("aged_a", {30'd0, bus.forward_a}, 32'd0);
        check("aged_b", {30'd0, bus.forward_b}, 32'd0);
        tick();

        // Two consecutive writers of $9: MEM wins.
        idle(); set_ex(9, 1'b1, 1'b0); tick();
        idle(); set_ex(9, 1'b1, 1'b0); tick();
        idle(); bus.ex_rs = 5'd9; #1;
        check("prio_a", {30'd0, bus.forward_a}, 32'b10);
        tick();

        // Load-use on rs: one stall cycle, then WB forwarding after the bubble.
        idle(); set_ex(10, 1'b1, 1'b1); bus.id_rs = 5'd10; #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        idle(); bus.id_rs = 5'd10; #1;
        check("lu_bubble", {31'd0, bus.stall}, 32'd0);
        check("lu_count", {28'd0, bus.stall_count}, 32'd1);
        tick();
        idle(); bus.ex_rs = 5'd10; #1;
        check("lu_fwd_a", {30'd0, bus.forward_a}, 32'b01);
        tick();

        // rt match only counts when the ID instruction reads rt.
        idle(); set_ex(10, 1'b1, 1'b1); bus.id_rs = 5'd3; bus.id_rt = 5'd10; #1;
        check("lu_rt_unused", {31'd0, bus.stall}, 32'd0);
        bus.id_uses_rt = 1'b1; #1;
        check("lu_rt_used", {31'd0, bus.stall}, 32'd1);
        tick();

        // Register 0 never forwards or stalls.
        idle(); set_ex(0, 1'b1, 1'b0); tick();
        idle(); bus.ex_rs = 5'd0; #1;
        check("zero_fwd", {30'd0, bus.forward_a}, 32'd0);
        tick();
        idle(); set_ex(0, 1'b1, 1'b1); bus.id_rs = 5'd0; #1;
        check("zero_stall", {31'd0, bus.stall}, 32'd0);
        tick();

        // Flush overrides stall and squashes the write.
        idle(); set_ex(11, 1'b1, 1'b1); bus.id_rs = 5'd11; bus.flush = 1'b1; #1;
        check("flush_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        idle(); bus.ex_rs = 5'd11; bus.ex_rt = 5'd11; #1;
        check("flush_fwd_a", {30'd0, bus.forward_a}, 32'd0);
        check("flush_fwd_b", {30'd0, bus.forward_b}, 32'd0);
        tick();

        // Hold a stalling load long enough to saturate the counter.
        idle(); set_ex(12, 1'b1, 1'b1); bus.id_rs = 5'd12;
        repeat (MAXCT + 4) tick();
        idle(); #1;
        check("sat_count", {28'd0, bus.stall_count}, MAXCT);
        tick();

        // Reset in mid-operation drops pending producers.
        idle(); set_ex(7, 1'b1, 1'b0); tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0; idle(); bus.ex_rs = 5'd7; bus.ex_rt = 5'd7; #1;
        check("mid_rst_fwd", {30'd0, bus.forward_a}, 32'd0);
        check("mid_rst_count", {28'd0, bus.stall_count}, 32'd0);
        tick();

        // Randomized traffic over a small register range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 59) == 0);
            bus.ex_valid     = $urandom_range(0, 3) != 0;
            bus.ex_dst       = AW'($urandom_range(0, 3));
            bus.ex_reg_write = $urandom_range(0, 3) != 0;
            bus.ex_mem_read  = $urandom_range(0, 1);
            bus.ex_rs        = AW'($urandom_range(0, 3));
            bus.ex_rt        = AW'($urandom_range(0, 3));
            bus.id_rs        = AW'($urandom_range(0, 3));
            bus.id_rt        = AW'($urandom_range(0, 3));
            bus.id_uses_rt   = $urandom_range(0, 1);
            bus.flush        = ($urandom_range(0, 7) == 0);
            tick();
        end

        rst = 1'b0;
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
- Consumes the EX-stage destination register number produced by the RegDst mux, which selects Rt or Rd.
- Carries that number, with its RegWrite/MemRead qualifiers, down a two-entry registered history covering the EX/MEM and MEM/WB stages.
- From that history it drives the ALU operand forwarding selects and the one-cycle load-use stall.
- Sits between the RegDst mux and the forwarding muxes in front of the ALU, and feeds the hazard/PC-hold logic.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_dst  in  REG_AW  selected write register of the instruction in EX (RegDst mux output).
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rs  in  REG_AW  EX source register A.
- ex_rt  in  REG_AW  EX source register B.
- id_rs  in  REG_AW  ID-stage source register A.
- id_rt  in  REG_AW  ID-stage source register B.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- flush  in  1  branch taken; the EX instruction is squashed.
- forward_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- forward_b  out  2  ALU operand B select, same encoding as forward_a.
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- mem_dst  out  REG_AW  registered EX/MEM destination.
- wb_dst  out  REG_AW  registered MEM/WB destination.
- wb_reg_write  out  1  registered MEM/WB write enable.
- stall_count  out  CNT_W  number of load-use stalls since reset.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1:
  - mem_dst, wb_dst, the internal mem_reg_write and wb_reg_write all clear to 0.
  - stall_count clears to 0.
  - Combinational outputs then evaluate to forward_a=00, forward_b=00, stall=0, because all history is invalid.
- History shift, every rising edge with rst=0:
  - MEM entry <= EX entry: ex_dst, and ex_reg_write & ex_valid & ~flush.
  - WB entry <= previous MEM entry.
  - No enable: the history always advances, including during stall. The stalled instruction stays in ID, and the bubble enters EX via ex_valid=0 on the next cycle.
- Register 0: any entry whose dst is 0 is treated as non-writing for forwarding and stall. It is still stored.
- forward_a, combinational, 0-cycle latency from history and ex_rs:
  - 10 if mem_reg_write & mem_dst!=0 & mem_dst==ex_rs;
  - else 01 if wb_reg_write & wb_dst!=0 & wb_dst==ex_rs;
  - else 00.
  - MEM has priority over WB when both match (simultaneous-writer case).
- forward_b: identical to forward_a, using ex_rt.
- stall, combinational:
  - stall = ex_valid & ex_mem_read & ex_reg_write & ~flush & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
  - Next cycle ex_valid=0 (the bubble), so stall deasserts. Stall length is exactly 1 cycle per load.
- flush and stall together: flush wins, stall=0, and the squashed entry enters MEM as non-writing.
- stall_count:
  - Increments by 1 on each edge where stall=1 and rst=0.
  - Saturates at all-ones; no wrap-around.
- Reset mid-operation: history is cleared on the same edge. Forwarding from pre-reset instructions never occurs afterwards.
- Latency: forwarding for a producer in EX at cycle n is visible to a consumer in EX at n+1 (select 10) and at n+2 (select 01).

Decomposition:
- Shared package pipe_pkg:
  - REG_AW, and REG_ZERO = 5'd0.
  - Forward-select encodings FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - Typedef dst_entry_t {dst, reg_write}.
- One natural sub-module, fwd_select. It is instantiated twice, for operand A and operand B. Inputs: src, MEM entry, WB entry. Output: the 2-bit select.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_dst=5, ex_reg_write=1, ex_valid=1 → after release, forward_a=forward_b=00, mem_dst=0, stall=0, stall_count=0.
- MEM/WB forwarding:
  - Cycle 0: add writes $8 (ex_dst=8).
  - Cycle 1: ex_rs=8 → forward_a=10.
  - Cycle 2: ex_rt=8 → forward_b=01.
  - Cycle 3: $8 no longer in history → forward selects 00.
- Priority: $9 written in two consecutive cycles, consumer ex_rs=9 → forward_a=10, not 01.
- Load-use:
  - lw in EX with ex_dst=10, id_rs=10 → stall=1 for exactly one cycle and stall_count=1.
  - The next cycle, ex_rs=10 → forward_a=01.
  - Repeat the load-use with id_rt=10, id_uses_rt=0 → stall=0.
- Zero register: ex_dst=0, ex_reg_write=1, followed by ex_rs=0 → forward_a=00. Also lw to $0 with id_rs=0 → stall=0.
- Flush: flush=1 with lw ex_dst=11 and id_rs=11 → stall=0. Next cycle ex_rs=11 → forward_a=00. stall_count preset near 2^CNT_W-1 and held there by repeated stalls → stall_count stays at all-ones.
